// File: rtl/qspi_rd_master.sv
// qspi_rd_master: single-bit 03h/0Bh read initiator for the QSPI link.
// Shifts out command and address, captures one 32-bit word, pulses rd_valid.
module qspi_rd_master #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cmd_fast,
  input  logic [23:0] rd_addr,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        qspi_csn,
  output logic        qspi_sck,
  output logic        qspi_di,
  input  logic        qspi_do,
  output logic        qspi_wpn,
  output logic        qspi_holdn
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(CS_GAP + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_FAST = 8'h0B;
  localparam logic [6:0] N_READ   = 7'd65;
  localparam logic [6:0] N_FAST   = 7'd73;
  localparam logic [6:0] D_READ   = 7'd32;
  localparam logic [6:0] D_FAST   = 7'd40;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    GAP
  } state_t;

  state_t        state_q;
  logic [DW-1:0] div_q;
  logic [GW-1:0] gap_q;
  logic [6:0]    bit_cnt_q;
  logic          fast_q;
  logic [46:0]   tx_q;
  logic [31:0]   rx_q;
  logic          csn_q;
  logic          sck_q;
  logic          di_q;
  logic          busy_q;
  logic          valid_q;
  logic [31:0]   data_q;

  logic          div_wrap;
  logic          gap_done;
  logic          last_pulse;
  logic          in_win;
  logic [6:0]    win_lo;
  logic [6:0]    bit_cnt_d;
  logic [DW-1:0] div_d;
  logic [GW-1:0] gap_d;
  logic [46:0]   tx_d;
  logic [31:0]   rx_d;
  logic [47:0]   tx_load;

  assign div_wrap   = (div_q == DIV_LAST);
  assign gap_done   = (gap_q == GAP_LAST);
  assign div_d      = div_q + 1'b1;
  assign gap_d      = gap_q + 1'b1;
  assign bit_cnt_d  = bit_cnt_q + 7'd1;
  assign last_pulse = (bit_cnt_q == (fast_q ? N_FAST : N_READ));
  assign win_lo     = fast_q ? D_FAST : D_READ;
  assign in_win     = (bit_cnt_q >= win_lo)
                   && (bit_cnt_q < win_lo + 7'd32);
  assign tx_d       = {tx_q[45:0], 1'b0};
  assign rx_d       = {rx_q[30:0], qspi_do};
  assign tx_load    = {cmd_fast ? CMD_FAST : CMD_READ,
                       rd_addr, 16'h0000};

  // bit_cnt_q counts SCK rises; it equals the index of the pulse being raised
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      gap_q     <= '0;
      bit_cnt_q <= '0;
      fast_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      csn_q     <= 1'b1;
      sck_q     <= 1'b0;
      di_q      <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= SHIFT_LO;
            busy_q    <= 1'b1;
            csn_q     <= 1'b0;
            sck_q     <= 1'b0;
            di_q      <= tx_load[47];
            tx_q      <= tx_load[46:0];
            fast_q    <= cmd_fast;
            bit_cnt_q <= '0;
            div_q     <= '0;
          end
        end
        SHIFT_LO: begin
          if (div_wrap) begin
            div_q     <= '0;
            sck_q     <= 1'b1;
            state_q   <= SHIFT_HI;
            bit_cnt_q <= bit_cnt_d;
            if (in_win) begin
              rx_q <= rx_d;
            end
          end else begin
            div_q <= div_d;
          end
        end
        SHIFT_HI: begin
          if (div_wrap) begin
            div_q <= '0;
            sck_q <= 1'b0;
            if (last_pulse) begin
              state_q <= GAP;
              csn_q   <= 1'b1;
              di_q    <= 1'b0;
              valid_q <= 1'b1;
              data_q  <= rx_q;
              gap_q   <= '0;
            end else begin
              state_q <= SHIFT_LO;
              di_q    <= tx_q[46];
              tx_q    <= tx_d;
            end
          end else begin
            div_q <= div_d;
          end
        end
        GAP: begin
          if (gap_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_d;
          end
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign rd_data    = data_q;
  assign rd_valid   = valid_q;
  assign qspi_csn   = csn_q;
  assign qspi_sck   = sck_q;
  assign qspi_di    = di_q;
  assign qspi_wpn   = 1'b1;
  assign qspi_holdn = 1'b1;

endmodule

// File: tb/tb_qspi_rd_master.sv
// tb_qspi_rd_master: two DUTs (CLK_DIV 2 and 1) against a cycle-level model
// derived from frame arithmetic, plus a behavioural responder on the link.
module tb_qspi_rd_master;

  localparam int GAP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rs [2];
  logic        st [2];
  logic        fst[2];
  logic [23:0] ad [2];
  logic        bsy[2];
  logic        vld[2];
  logic        csn[2];
  logic        sck[2];
  logic        di [2];
  logic        dq [2];
  logic        wpn[2];
  logic        hld[2];
  logic [31:0] dat[2];

  qspi_rd_master #(.CLK_DIV(2), .CS_GAP(GAP)) u_d2 (
    .sys_clk(clk), .rst(rs[0]), .start(st[0]),
    .cmd_fast(fst[0]), .rd_addr(ad[0]), .busy(bsy[0]),
    .rd_data(dat[0]), .rd_valid(vld[0]), .qspi_csn(csn[0]),
    .qspi_sck(sck[0]), .qspi_di(di[0]), .qspi_do(dq[0]),
    .qspi_wpn(wpn[0]), .qspi_holdn(hld[0])
  );

  qspi_rd_master #(.CLK_DIV(1), .CS_GAP(GAP)) u_d1 (
    .sys_clk(clk), .rst(rs[1]), .start(st[1]),
    .cmd_fast(fst[1]), .rd_addr(ad[1]), .busy(bsy[1]),
    .rd_data(dat[1]), .rd_valid(vld[1]), .qspi_csn(csn[1]),
    .qspi_sck(sck[1]), .qspi_di(di[1]), .qspi_do(dq[1]),
    .qspi_wpn(wpn[1]), .qspi_holdn(hld[1])
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  logic chk_en = 1'b0;

  logic        fixed_en[2];
  logic [31:0] fixed_w [2];

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  function automatic int cdv(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int npulse(input logic f);
    return f ? 73 : 65;
  endfunction

  function automatic logic [31:0] resp_w(input int i,
      input logic [23:0] a, input logic f);
    if (fixed_en[i]) return fixed_w[i];
    return {a[7:0] ^ {7'b0, f}, a[23:16], ~a[15:8], a[7:0] + 8'h5A};
  endfunction

  // Reference model: frame acceptance and timing from arithmetic
  int          m_t0  [2] = '{0, 0};
  int          m_n   [2] = '{65, 65};
  int          m_free[2] = '{0, 0};
  int          m_rstc[2] = '{-10, -10};
  int          m_acc [2] = '{0, 0};
  logic        m_act [2] = '{1'b0, 1'b0};
  logic        m_fast[2];
  logic [23:0] m_addr[2];
  logic [31:0] m_word[2];
  logic [31:0] m_data[2] = '{32'h0, 32'h0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rs[i]) begin
        m_act[i]  = 1'b0;
        m_free[i] = cyc + 1;
        m_rstc[i] = cyc;
      end else if (st[i] && cyc >= m_free[i]) begin
        m_act[i]  = 1'b1;
        m_t0[i]   = cyc;
        m_fast[i] = fst[i];
        m_addr[i] = ad[i];
        m_word[i] = resp_w(i, ad[i], fst[i]);
        m_n[i]    = npulse(fst[i]);
        m_free[i] = cyc + 1 + 2 * m_n[i] * cdv(i) + GAP;
        m_acc[i]++;
      end
    end
    cyc++;
  end

  // Responder state and frame records
  logic        ps[2] = '{1'b0, 1'b0};
  logic        pc[2] = '{1'b1, 1'b1};
  int          rc[2] = '{0, 0};
  logic [72:0] dec[2];
  logic [7:0]  r_cmd[2];
  logic [31:0] r_word[2];
  int          f_rises[2] = '{0, 0};
  logic [72:0] f_dec[2];
  int          vcnt[2] = '{0, 0};
  int          end_cyc[2] = '{0, 0};
  logic        end_ok[2] = '{1'b0, 1'b0};

  int          n_o, n_n2, n_d;
  logic [72:0] n_s;
  logic        e_csn, e_sck, e_di, e_bsy, e_vld;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (csn[i] !== 1'b0) begin
        if (!pc[i]) begin
          f_rises[i] = rc[i];
          f_dec[i]   = dec[i];
          end_cyc[i] = cyc;
          end_ok[i]  = (vld[i] === 1'b1);
        end
        rc[i] = 0;
        dq[i] = 1'b0;
        pc[i] = 1'b1;
      end else begin
        if (pc[i] && end_ok[i] && chk_en)
          chk($sformatf("cs_gap_u%0d", i),
              64'(cyc - end_cyc[i] >= GAP + 1), 64'd1);
        if (sck[i] && !ps[i]) begin
          dec[i] = {dec[i][71:0], di[i]};
          rc[i]++;
          if (rc[i] == 8) r_cmd[i] = dec[i][7:0];
          if (rc[i] == 32)
            r_word[i] = resp_w(i, dec[i][23:0], r_cmd[i] == 8'h0B);
        end else if (!sck[i] && ps[i]) begin
          n_d = (r_cmd[i] == 8'h0B) ? 40 : 32;
          if (rc[i] >= n_d && rc[i] < n_d + 32)
            dq[i] = r_word[i][31 - (rc[i] - n_d)];
          else
            dq[i] = 1'b0;
        end
        pc[i] = 1'b0;
      end
      ps[i] = sck[i];
      if (vld[i] === 1'b1) vcnt[i]++;

      e_csn = 1'b1; e_sck = 1'b0; e_di = 1'b0;
      e_bsy = 1'b0; e_vld = 1'b0;
      if (cyc == m_rstc[i] + 1) m_data[i] = 32'h0;
      if (m_act[i]) begin
        n_n2 = 2 * m_n[i] * cdv(i);
        if (cyc >= m_t0[i] + 1 && cyc <= m_t0[i] + n_n2) begin
          n_o   = cyc - m_t0[i] - 1;
          n_s   = {m_fast[i] ? 8'h0B : 8'h03, m_addr[i], 41'b0};
          e_csn = 1'b0;
          e_sck = ((n_o / cdv(i)) % 2) == 1;
          e_di  = n_s[72 - n_o / (2 * cdv(i))];
        end
        if (cyc >= m_t0[i] + 1 && cyc < m_free[i]) e_bsy = 1'b1;
        if (cyc == m_t0[i] + 1 + n_n2) begin
          e_vld     = 1'b1;
          m_data[i] = m_word[i];
        end
      end
      if (chk_en)
        chk($sformatf("cycle%0d_u%0d", cyc, i),
            {csn[i], sck[i], di[i], bsy[i], vld[i], dat[i]},
            {e_csn, e_sck, e_di, e_bsy, e_vld, m_data[i]});
    end
  end

  typedef struct {
    int          inst;
    logic        fast;
    logic [23:0] addr;
    logic [31:0] word;
    int          lat;
    int          rises;
  } vec_t;

  task automatic wait_idle(input int i, input string nm);
    int t = 0;
    while (bsy[i] !== 1'b0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_idle"}, 64'(bsy[i]), 64'd0);
  endtask

  task automatic run_frame(input int i, input logic f,
      input logic [23:0] a, input logic fx, input logic [31:0] w,
      input int lat, input int nr, input string nm);
    int          t0, t;
    logic [31:0] ew;
    logic [72:0] sh;
    wait_idle(i, nm);
    fixed_en[i] = fx;
    fixed_w[i]  = w;
    ew = resp_w(i, a, f);
    fst[i] = f;
    ad[i]  = a;
    st[i]  = 1'b1;
    t0 = cyc;
    @(negedge clk);
    st[i]  = 1'b0;
    fst[i] = 1'($urandom);
    ad[i]  = 24'($urandom);
    t = 0;
    while (vld[i] !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_lat"}, 64'(cyc - t0), 64'(lat));
    chk({nm, "_data"}, 64'(dat[i]), 64'(ew));
    @(negedge clk);
    chk({nm, "_rises"}, 64'(f_rises[i]), 64'(nr));
    sh = f_dec[i] >> (f_rises[i] - 8);
    chk({nm, "_cmd"}, 64'(sh[7:0]), f ? 64'h0B : 64'h03);
    sh = f_dec[i] >> (f_rises[i] - 32);
    chk({nm, "_addr"}, 64'(sh[23:0]), 64'(a));
    if (f) begin
      sh = f_dec[i] >> (f_rises[i] - 40);
      chk({nm, "_dummy"}, 64'(sh[7:0]), 64'd0);
    end
    t = 0;
    while (bsy[i] !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_busy"}, 64'(cyc - t0), 64'(lat + GAP));
  endtask

  initial begin
    vec_t        tbl[6];
    int          v0, a0, t;
    logic        f;
    logic [23:0] a;

    tbl[0] = '{0, 1'b0, 24'h000120, 32'hA5A51234, 261, 65};
    tbl[1] = '{0, 1'b1, 24'hABCDE5, 32'hDEADBEEF, 293, 73};
    tbl[2] = '{0, 1'b0, 24'hFFFFFF, 32'hFFFFFFFF, 261, 65};
    tbl[3] = '{0, 1'b1, 24'h000000, 32'h00000001, 293, 73};
    tbl[4] = '{0, 1'b0, 24'h800001, 32'h80000000, 261, 65};
    tbl[5] = '{1, 1'b1, 24'h5A5A5A, 32'h12345678, 147, 73};

    for (int i = 0; i < 2; i++) begin
      rs[i] = 1'b1; st[i] = 1'b0; fst[i] = 1'b0; ad[i] = '0;
      fixed_en[i] = 1'b1; fixed_w[i] = '0;
    end

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        st[i]  = 1'($urandom);
        fst[i] = 1'($urandom);
        ad[i]  = 24'($urandom);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      rs[i] = 1'b0;
      st[i] = 1'b0;
    end
    @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_csn_u%0d", i), 64'(csn[i]), 64'd1);
      chk($sformatf("rst_sck_u%0d", i), 64'(sck[i]), 64'd0);
      chk($sformatf("rst_di_u%0d", i), 64'(di[i]), 64'd0);
      chk($sformatf("rst_busy_u%0d", i), 64'(bsy[i]), 64'd0);
      chk($sformatf("rst_valid_u%0d", i), 64'(vld[i]), 64'd0);
      chk($sformatf("rst_data_u%0d", i), 64'(dat[i]), 64'd0);
    end

    for (int k = 0; k < 6; k++)
      run_frame(tbl[k].inst, tbl[k].fast, tbl[k].addr, 1'b1,
                tbl[k].word, tbl[k].lat, tbl[k].rises,
                $sformatf("vec%0d", k));

    wait_idle(0, "abort_pre");
    fixed_en[0] = 1'b1;
    fixed_w[0]  = 32'hCAFEF00D;
    fst[0] = 1'b0;
    ad[0]  = 24'h3C3C3C;
    st[0]  = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    t = 0;
    while (rc[0] < 18 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("abort_reach", 64'(rc[0] >= 18), 64'd1);
    rs[0] = 1'b1;
    v0 = vcnt[0];
    @(negedge clk);
    rs[0] = 1'b0;
    chk("abort_csn", 64'(csn[0]), 64'd1);
    chk("abort_sck", 64'(sck[0]), 64'd0);
    chk("abort_busy", 64'(bsy[0]), 64'd0);
    repeat (300) @(negedge clk);
    chk("abort_novalid", 64'(vcnt[0] - v0), 64'd0);
    run_frame(0, 1'b0, 24'h000040, 1'b1, 32'h0BADF00D, 261, 65,
              "post_abort");

    fixed_en[0] = 1'b0;
    v0 = vcnt[0];
    a0 = m_acc[0];
    for (int k = 0; k < 700; k++) begin
      st[0]  = 1'b1;
      fst[0] = ~fst[0];
      ad[0]  = 24'($urandom);
      @(negedge clk);
    end
    st[0] = 1'b0;
    wait_idle(0, "b2b");
    chk("b2b_frames", 64'(vcnt[0] - v0), 64'(m_acc[0] - a0));
    chk("b2b_count", 64'(m_acc[0] - a0 >= 2), 64'd1);

    for (int k = 0; k < 8; k++) begin
      f = 1'($urandom);
      a = 24'($urandom);
      run_frame(k % 2, f, a, 1'b0, 32'h0,
                1 + 2 * npulse(f) * cdv(k % 2), npulse(f),
                $sformatf("rnd%0d", k));
    end

    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
